spi_sclk_engine: RTL and testbench

Parametrised SPI serial-clock engine. It replaces the fixed-width, mode-0-only SPI clock generator with programmable divider width, CPOL/CPHA mode, and a built-in transfer-length counter. It also provides a busy/done handshake and an abort input. It sits between the SPI register block, which supplies go, the configuration and abort, and the shift register, which consumes sample, shift and load.

---
 rtl/spi_sclk_engine_pkg.sv | 19 +
 rtl/spi_half_period_cnt.sv | 25 ++
 rtl/spi_sclk_engine.sv | 140 ++++++++++++++
 tb/tb_spi_sclk_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spi_sclk_engine_pkg.sv
// Shared types and defaults for the SPI serial-clock engine.
// Mode constants are packed as {cpol, cpha}.
package spi_sclk_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_LEN_W = 8;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable half-period down-counter; reloads load_val on reaching zero while enabled.
module spi_half_period_cnt
  import spi_sclk_engine_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)       cnt <= '1;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= (cnt == '0) ? load_val : cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: programmable half-period, CPOL/CPHA, transfer length,
// busy/done handshake and abort. All outputs are registered.
module spi_sclk_engine
  import spi_sclk_engine_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] divider,
  input  logic [LEN_W-1:0] nbits,
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             sample,
  output logic             shift,
  output logic             load,
  output logic             busy,
  output logic             done
);

  localparam int EW = LEN_W + 2;

  state_t           state, state_d;
  logic [EW-1:0]    ecnt, ecnt_d;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q, cpha_q;
  logic             sclk_d, pos_d, neg_d, smp_d, shf_d, load_d, busy_d, done_d;
  logic             start, zero, lead;

  spi_half_period_cnt #(.DIV_W(DIV_W)) u_hcnt (
    .clk_in   (clk_in),
    .rst      (rst),
    .load     (start),
    .en       (state != ST_IDLE),
    .load_val (start ? divider : div_q),
    .zero     (zero)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    ecnt_d  = ecnt;
    sclk_d  = sclk;
    busy_d  = busy;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    smp_d   = 1'b0;
    shf_d   = 1'b0;
    load_d  = 1'b0;
    done_d  = 1'b0;
    start   = 1'b0;
    lead    = 1'b0;
    case (state)
      ST_IDLE: begin
        sclk_d = cpol;
        busy_d = 1'b0;
        if (go && !abort) begin
          start   = 1'b1;
          state_d = ST_RUN;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          // nbits==0 encodes a full 2^LEN_W cycles, i.e. 2^(LEN_W+1) toggles
          ecnt_d  = (nbits == '0) ? {1'b1, {(EW-1){1'b0}}} : {1'b0, nbits, 1'b0};
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
          busy_d  = 1'b0;
        end else if (zero) begin
          // counter starts even, so an even remaining count marks a leading edge
          lead   = ~ecnt[0];
          sclk_d = ~sclk;
          pos_d  = ~sclk;
          neg_d  = sclk;
          smp_d  = cpha_q ? ~lead : lead;
          shf_d  = cpha_q ? lead : (~lead && (ecnt != EW'(1)));
          ecnt_d = ecnt - 1'b1;
          if (ecnt == EW'(1)) state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
          busy_d  = 1'b0;
        end else if (zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ecnt     <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      sample   <= 1'b0;
      shift    <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ecnt     <= ecnt_d;
      sclk     <= sclk_d;
      pos_edge <= pos_d;
      neg_edge <= neg_d;
      sample   <= smp_d;
      shift    <= shf_d;
      load     <= load_d;
      busy     <= busy_d;
      done     <= done_d;
      if (start) begin
        div_q  <= divider;
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: per-cycle comparison against an arithmetic model of
// toggle times derived from go time, divider and transfer length.
module tb_spi_sclk_engine;

  localparam int DIV_W = 16;
  localparam int LEN_W = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [DIV_W-1:0] divider = '0;
  logic [LEN_W-1:0] nbits = '0;
  logic sclk, pos_edge, neg_edge, sample, shift, load, busy, done;

  int total = 0, bad = 0;
  int c = 0;
  bit have = 1'b0;
  bit m_cpol, m_cpha;
  int m_t0, m_d, m_e, m_done;

  spi_sclk_engine #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk_in(clk_in), .rst(rst), .go(go), .abort(abort), .cpol(cpol), .cpha(cpha),
    .divider(divider), .nbits(nbits), .sclk(sclk), .pos_edge(pos_edge),
    .neg_edge(neg_edge), .sample(sample), .shift(shift), .load(load),
    .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] obs();
    return {sclk, pos_edge, neg_edge, sample, shift, load, busy, done};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (sclk,pos,neg,smp,shf,load,busy,done)",
               tag, c, got, exp);
    end
  endtask

  // Drives one cycle of inputs, predicts next-cycle outputs, clocks and compares.
  task automatic step(input logic g, input logic a, input string tag);
    logic [7:0] e;
    int t, q, r, k;
    bit s, tog, lead;
    go = g;
    abort = a;
    if (a && have && c > m_t0 && (c - m_t0) < m_done) begin
      have = 1'b0;
      e = {m_cpol, 7'b0};
    end else begin
      if (g && !a && (!have || (c - m_t0) >= m_done)) begin
        have   = 1'b1;
        m_t0   = c;
        m_cpol = cpol;
        m_cpha = cpha;
        m_d    = int'(divider);
        m_e    = (nbits == '0) ? 2 * (1 << LEN_W) : 2 * int'(nbits);
        m_done = 1 + (m_e + 1) * (m_d + 1);
      end
      t = c + 1 - m_t0;
      if (have && t >= 1 && t <= m_done) begin
        q    = (t - 1) / (m_d + 1);
        r    = (t - 1) % (m_d + 1);
        k    = (q < m_e) ? q : m_e;
        s    = m_cpol ^ ((k % 2) == 1);
        tog  = (r == 0) && (q >= 1) && (q <= m_e);
        lead = (q % 2) == 1;
        e = {s, tog && s, tog && !s,
             tog && (m_cpha ? !lead : lead),
             tog && (m_cpha ? lead : (!lead && q != m_e)),
             t == 1, t < m_done, t == m_done};
      end else begin
        e = {cpol, 7'b0};
      end
    end
    @(posedge clk_in);
    #1;
    c++;
    check(tag, obs(), e);
  endtask

  task automatic rcfg();
    cpol    = 1'($urandom);
    cpha    = 1'($urandom);
    divider = ($urandom_range(0, 7) == 0) ? DIV_W'(7) : DIV_W'($urandom_range(0, 3));
    nbits   = LEN_W'($urandom_range(1, 6));
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    check("reset", obs(), 8'h00);
    rst = 1'b0;

    // mode 0, config changed mid-transfer must not affect timing
    cpol = 0; cpha = 0; divider = 1; nbits = 2;
    step(1, 0, "mode0");
    repeat (3) step(0, 0, "mode0");
    divider = 5; nbits = 7; cpha = 1;
    repeat (9) step(0, 0, "mode0_frz");

    // mode 3
    cpol = 1; cpha = 1; divider = 0; nbits = 1;
    step(0, 0, "mode3_idle");
    step(1, 0, "mode3");
    repeat (5) step(0, 0, "mode3");

    // length wrap: nbits=0 -> 512 toggles
    cpol = 1; cpha = 0; divider = 0; nbits = 0;
    step(1, 0, "wrap");
    repeat (520) step(0, 0, "wrap");

    // abort after third toggle, then full restart
    cpol = 0; cpha = 0; divider = 2; nbits = 8;
    step(1, 0, "abort_pre");
    repeat (9) step(0, 0, "abort_pre");
    step(0, 1, "abort");
    step(1, 0, "restart");
    repeat (60) step(0, 0, "restart");

    // go while busy ignored; go in done cycle accepted
    cpol = 0; cpha = 1; divider = 1; nbits = 2;
    step(1, 0, "b2b");
    step(1, 0, "go_busy");
    repeat (9) step(0, 0, "b2b");
    step(1, 0, "b2b_go");
    repeat (12) step(0, 0, "b2b2");

    // abort and go together in idle: abort wins
    step(1, 1, "abort_go_idle");
    repeat (3) step(0, 0, "abort_go_idle");

    repeat (3000) begin
      rcfg();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, "rand");
    end

    // asynchronous reset mid-transfer
    cpol = 1; cpha = 0; divider = 1; nbits = 4;
    step(1, 0, "arst_pre");
    repeat (5) step(0, 0, "arst_pre");
    #2 rst = 1'b1;
    #1 check("arst", obs(), 8'h00);
    @(posedge clk_in);
    #1;
    c++;
    check("arst_hold", obs(), 8'h00);
    rst = 1'b0;
    have = 1'b0;
    repeat (5) step(0, 0, "post_rst");
    step(1, 0, "post_rst_go");
    repeat (20) step(0, 0, "post_rst_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
